wos_rank_select: RTL and testbench
==================================

// Module: wos_rank_select
// PURPOSE
//  Weighted order-statistic selector; sits directly downstream of the sample window shift register.
//  Takes one packed window of N samples plus per-tap weights and a rank threshold.
//  Outputs the weighted rank-order value: the smallest x_i with S_i >= thresh,
//  where S_i = sum of w_j over all j with x_j <= x_i.
//  Iterative core: one candidate per clock, N scan clocks per window; valid/ready on both sides.
// PARAMETERS
//  bits  8  sample width (unsigned)
//  N     9  taps per window (N >= 2)
//  WW    4  weight width (unsigned)
//  SW    WW+$clog2(N)+1  accumulated-weight / threshold width (derived, not overridden)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        reset, asynchronous, active-low
//  in_valid   in   1        window/weights/thresh valid
//  in_ready   out  1        block can accept a window
//  window     in   bits*N   tap i at [bits*i +: bits]; tap 0 newest
//  weights    in   WW*N     w_i at [WW*i +: WW]
//  thresh     in   SW       rank threshold T
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  out_data   out  bits     selected sample
//  out_miss   out  1        no tap reached T (T > sum of all weights)
// BEHAVIOUR
//  Reset (rst low, async): state=IDLE; in_ready=1; out_valid=0; out_data=0; out_miss=0;
//   internal window/weight/T copies, index, best and found flag cleared.
//  FSM IDLE -> SCAN -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid at a clock edge: register window, weights, thresh;
//   idx=0, found=0, best=0; go to SCAN.
//  SCAN: in_ready=0; inputs ignored. Each clock evaluates candidate x_idx:
//   S_idx = sum over j of (x_j <= x_idx ? w_j : 0), full SW width, no overflow.
//   If S_idx >= T and (found==0 or x_idx < best): best=x_idx, found=1.
//   Track running max sample for the miss case.
//   idx increments 0..N-1; on the idx==N-1 edge, load out_data/out_miss and go to DONE.
//  DONE: out_valid=1; out_data/out_miss held stable while out_ready=0.
//   On out_ready at a clock edge: out_valid=0; go to IDLE.
//   out_data keeps its last value after the handshake.
//  Latency: out_valid rises exactly N clocks after the accept edge.
//   Throughput: one window per N+2 clocks with out_ready held high.
//  found==0 after the scan: out_data = max sample, out_miss=1.
//   Otherwise out_miss=0.
//  T=0: every candidate qualifies; result is the window minimum.
//  Equal samples: each receives the same S; result value is independent of tap order.
//  All-zero weights: T=0 gives the window minimum; T>=1 gives a miss.
//  Comparisons and sums are unsigned. The result is purely combinatorial in the registered
//   copies, so a change on window/thresh after accept has no effect.
//  Reset mid-SCAN or mid-DONE: immediate abort to reset state; the pending result is lost.
// TESTING
//  N=9, x_i=10*i, all w=1, T=5 -> out_data=40, miss=0; out_valid exactly 9 clocks after accept.
//  Same window: T=1 -> 0; T=9 -> 80; T=10 -> out_data=80, out_miss=1.
//  x_i=10*(i+1), w0=5, others 1: T=5 -> 10; T=6 -> 20; T=13 -> 90.
//  All x=7, w=1, T=3 -> 7. All w=0: T=0 -> min, miss=0; T=1 -> miss=1.
//  Hold out_ready=0 for 3 clocks in DONE -> out_valid/out_data stable, in_ready=0.
//   Release -> one handshake, return to IDLE.
//  Back-to-back windows with out_ready=1 -> accepts every N+2 clocks, results in order.
//   Assert rst at SCAN idx=4 -> outputs at reset values immediately; next window is correct.

Source files
------------

// File: rtl/wos_rank_select.sv
// Weighted order-statistic selector. Scans one candidate tap per clock and
// returns the smallest sample whose cumulative weight (weights of all taps
// with a sample <= it) reaches the rank threshold.
module wos_rank_select #(
  parameter int unsigned bits = 8,
  parameter int unsigned N    = 9,
  parameter int unsigned WW   = 4,
  localparam int unsigned SW  = WW + $clog2(N) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [bits*N-1:0] window,
  input  logic [WW*N-1:0] weights,
  input  logic [SW-1:0]   thresh,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [bits-1:0] out_data,
  output logic            out_miss
);

  localparam int unsigned IW = $clog2(N);
  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e state_q, state_d;

  logic [bits*N-1:0] win_q;
  logic [WW*N-1:0]   wgt_q;
  logic [SW-1:0]     thr_q;
  logic [IW-1:0]     idx_q;
  logic [bits-1:0]   best_q, best_d;
  logic [bits-1:0]   max_q, max_d;
  logic              found_q, found_d;
  logic [bits-1:0]   out_data_q;
  logic              out_miss_q;

  logic [bits-1:0]   cand;
  logic [SW-1:0]     wsum;
  logic              take;
  logic              last;

  assign last     = (idx_q == LastIdx);
  assign out_data = out_data_q;
  assign out_miss = out_miss_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StScan;
      end
      StScan: begin
        if (last) state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Candidate evaluation: cumulative weight of the current tap and best/max update.
  always_comb begin
    cand = '0;
    for (int j = 0; j < N; j++) begin
      if (idx_q == IW'(j)) cand = win_q[bits*j +: bits];
    end
    wsum = '0;
    for (int j = 0; j < N; j++) begin
      if (win_q[bits*j +: bits] <= cand) wsum = wsum + SW'(wgt_q[WW*j +: WW]);
    end
    take    = (wsum >= thr_q) && (!found_q || (cand < best_q));
    best_d  = take ? cand : best_q;
    found_d = found_q | take;
    max_d   = (cand > max_q) ? cand : max_q;
  end

  // Datapath registers: capture on accept, step during scan, load result on last tap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q      <= '0;
      wgt_q      <= '0;
      thr_q      <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      max_q      <= '0;
      found_q    <= 1'b0;
      out_data_q <= '0;
      out_miss_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            win_q   <= window;
            wgt_q   <= weights;
            thr_q   <= thresh;
            idx_q   <= '0;
            best_q  <= '0;
            max_q   <= '0;
            found_q <= 1'b0;
          end
        end
        StScan: begin
          idx_q   <= idx_q + 1'b1;
          best_q  <= best_d;
          found_q <= found_d;
          max_q   <= max_d;
          if (last) begin
            // No qualifying tap means T exceeds the total weight: report the maximum.
            out_data_q <= found_d ? best_d : max_d;
            out_miss_q <= ~found_d;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wos_rank_select.sv
// Self-checking bench for wos_rank_select: directed cases plus randomized
// windows checked against a value-sweep reference model.
module tb_wos_rank_select;

  localparam int unsigned BITS = 8;
  localparam int unsigned N    = 9;
  localparam int unsigned WW   = 4;
  localparam int unsigned SW   = WW + $clog2(N) + 1;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [BITS*N-1:0] window;
  logic [WW*N-1:0]   weights;
  logic [SW-1:0]     thresh;
  logic              out_valid;
  logic              out_ready;
  logic [BITS-1:0]   out_data;
  logic              out_miss;

  int checks;
  int failures;
  int cyc;

  int unsigned xs[N];
  int unsigned ws[N];

  wos_rank_select dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .window    (window),
    .weights   (weights),
    .thresh    (thresh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_miss  (out_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: sweep every sample value upward; the first value present in the
  // window whose weight mass of samples <= it reaches T is the answer.
  task automatic ref_model(input int unsigned t, output int unsigned d, output int unsigned m);
    bit hit;
    hit = 0;
    d   = 0;
    m   = 1;
    for (int v = 0; v < (1 << BITS); v++) begin
      bit present;
      int unsigned s;
      present = 0;
      s       = 0;
      for (int j = 0; j < N; j++) begin
        if (xs[j] == v) present = 1;
        if (xs[j] <= v) s += ws[j];
      end
      if (!hit && present && s >= t) begin
        hit = 1;
        d   = v;
        m   = 0;
      end
    end
    if (!hit) begin
      for (int j = 0; j < N; j++) if (xs[j] > d) d = xs[j];
    end
  endtask

  task automatic pack_inputs(input int unsigned t);
    for (int j = 0; j < N; j++) begin
      window[BITS*j +: BITS] = BITS'(xs[j]);
      weights[WW*j +: WW]    = WW'(ws[j]);
    end
    thresh = SW'(t);
  endtask

  task automatic scramble_inputs();
    window  = (BITS*N)'({$urandom(), $urandom(), $urandom()});
    weights = (WW*N)'({$urandom(), $urandom()});
    thresh  = SW'($urandom());
  endtask

  // One full transaction from IDLE; called #1 after a rising edge.
  task automatic send(input string tag, input int unsigned t, input int unsigned exp_d,
                      input int unsigned exp_m, input int unsigned hold);
    int lat;
    logic [BITS-1:0] held;
    check_eq({tag, ".in_ready_idle"}, in_ready, 1);
    pack_inputs(t);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble_inputs();
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, ".latency"}, lat, N);
    check_eq({tag, ".data"}, out_data, exp_d);
    check_eq({tag, ".miss"}, out_miss, exp_m);
    held = out_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check_eq({tag, ".hold_valid"}, out_valid, 1);
      check_eq({tag, ".hold_data"}, out_data, held);
      check_eq({tag, ".hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, ".valid_after_hs"}, out_valid, 0);
    check_eq({tag, ".ready_after_hs"}, in_ready, 1);
    check_eq({tag, ".data_kept"}, out_data, held);
  endtask

  task automatic set_ramp(input int unsigned base, input int unsigned w);
    for (int j = 0; j < N; j++) begin
      xs[j] = base + 10 * j;
      ws[j] = w;
    end
  endtask

  task automatic randomize_window();
    int unsigned span;
    span = ($urandom_range(0, 1) == 0) ? 8 : 255;
    for (int j = 0; j < N; j++) begin
      xs[j] = $urandom_range(0, span);
      ws[j] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, (1 << WW) - 1);
    end
  endtask

  int unsigned ed, em, tot, tt, prev_acc;
  int unsigned q_d[$];
  int unsigned q_m[$];

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    window    = '0;
    weights   = '0;
    thresh    = '0;
    #12;
    check_eq("reset.in_ready", in_ready, 1);
    check_eq("reset.out_valid", out_valid, 0);
    check_eq("reset.out_data", out_data, 0);
    check_eq("reset.out_miss", out_miss, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Ramp 0..80, unit weights.
    set_ramp(0, 1);
    send("ramp_t5", 5, 40, 0, 0);
    send("ramp_t1", 1, 0, 0, 3);
    send("ramp_t9", 9, 80, 0, 0);
    send("ramp_t10", 10, 80, 1, 1);
    send("ramp_t0", 0, 0, 0, 0);

    // Heavy newest tap.
    set_ramp(10, 1);
    ws[0] = 5;
    send("heavy_t5", 5, 10, 0, 0);
    send("heavy_t6", 6, 20, 0, 0);
    send("heavy_t13", 13, 90, 0, 0);
    send("heavy_t14", 14, 90, 1, 0);

    // Equal samples.
    for (int j = 0; j < N; j++) begin
      xs[j] = 7;
      ws[j] = 1;
    end
    send("equal_t3", 3, 7, 0, 0);

    // All-zero weights.
    set_ramp(10, 0);
    send("zero_w_t0", 0, 10, 0, 0);
    send("zero_w_t1", 1, 90, 1, 0);

    // Reset in the middle of a scan, then a normal window.
    set_ramp(0, 1);
    pack_inputs(5);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("midscan.in_ready_busy", in_ready, 0);
    rst = 1'b0;
    #1;
    check_eq("midscan.in_ready", in_ready, 1);
    check_eq("midscan.out_valid", out_valid, 0);
    check_eq("midscan.out_data", out_data, 0);
    check_eq("midscan.out_miss", out_miss, 0);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midscan.no_result", out_valid, 0);
    set_ramp(10, 1);
    ws[0] = 5;
    send("after_rst", 6, 20, 0, 0);

    // Back-to-back windows with out_ready held high.
    out_ready = 1'b1;
    prev_acc  = 0;
    for (int k = 0; k < 5; k++) begin
      int lat;
      randomize_window();
      tot = 0;
      for (int j = 0; j < N; j++) tot += ws[j];
      tt = $urandom_range(0, tot + 2);
      ref_model(tt, ed, em);
      pack_inputs(tt);
      in_valid = 1'b1;
      lat = 0;
      while (!in_ready && lat < 40) begin
        @(posedge clk);
        #1;
        lat++;
      end
      @(posedge clk);
      #1;
      if (k > 0) check_eq("b2b.spacing", cyc - prev_acc, N + 2);
      prev_acc = cyc;
      scramble_inputs();
      lat = 0;
      while (!out_valid && lat < 40) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check_eq("b2b.latency", lat, N);
      check_eq("b2b.data", out_data, ed);
      check_eq("b2b.miss", out_miss, em);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Randomized windows against the reference model.
    for (int k = 0; k < 60; k++) begin
      randomize_window();
      tot = 0;
      for (int j = 0; j < N; j++) tot += ws[j];
      case ($urandom_range(0, 3))
        0:       tt = 0;
        1:       tt = tot + $urandom_range(1, 3);
        default: tt = $urandom_range(0, tot);
      endcase
      ref_model(tt, ed, em);
      send("rand", tt, ed, em, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "time limit reached");
  end

endmodule
